// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding and width helpers for the iterative square-root unit
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int root_w(int dw, int fb);
    return (dw + fb) / 2;
  endfunction
  function automatic int rem_w(int dw, int fb);
    return (dw + fb) / 2 + 1;
  endfunction
  function automatic bit width_ok(int dw, int fb);
    return ((dw + fb) % 2 == 0) && (dw + fb >= 4);
  endfunction
endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational non-restoring square-root iteration (two radicand bits in, one root bit out)
module sqrt_step #(
  parameter int ROOT_W = 16
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        bits,
  output logic [ROOT_W+1:0] rem_next,
  output logic              root_bit
);
  logic [ROOT_W+1:0] shifted;
  logic [ROOT_W+1:0] term;
  // a non-negative remainder subtracts root<<2|1, a negative one adds root<<2|3
  assign shifted  = (rem << 2) | {{ROOT_W{1'b0}}, bits};
  assign term     = {root, rem[ROOT_W+1], 1'b1};
  assign rem_next = rem[ROOT_W+1] ? shifted + term : shifted - term;
  assign root_bit = ~rem_next[ROOT_W+1];
endmodule

// File: rtl/sqrt_iter.sv
// sqrt_iter: bit-serial non-restoring square root with valid/ready handshake; SQRT_ITER_ROUND_EN enables round-to-nearest root
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FRAC_BITS  = 0,
  localparam int ROOT_W     = root_w(DATA_WIDTH, FRAC_BITS),
  localparam int REM_W      = rem_w(DATA_WIDTH, FRAC_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROOT_W-1:0]     out_root,
  output logic [REM_W-1:0]      out_rem
);
  localparam int CW = $clog2(ROOT_W);
  if (!width_ok(DATA_WIDTH, FRAC_BITS)) begin : g_bad_width
    $error("sqrt_iter: DATA_WIDTH+FRAC_BITS must be even and >= 4");
  end
  state_t            state, state_next;
  logic [2*ROOT_W-1:0] rad;
  logic [REM_W:0]    rem, rem_step, rem_fix;
  logic [ROOT_W-1:0] root, root_fin;
  logic [CW-1:0]     cnt;
  logic              root_bit;
  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem      (rem),
    .root     (root),
    .bits     (rad[2*ROOT_W-1 -: 2]),
    .rem_next (rem_step),
    .root_bit (root_bit)
  );
  assign rem_fix = rem[REM_W] ? rem + (REM_W+1)'({root, 1'b1}) : rem;
`ifdef SQRT_ITER_ROUND_EN
  assign root_fin = (rem_fix[REM_W-1:0] > REM_W'(root) && root != '1) ? root + 1'b1 : root;
`else
  assign root_fin = root;
`endif
  assign out_root = root;
  assign out_rem  = rem[REM_W-1:0];
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next-state and handshake outputs
  always_comb begin
    in_ready   = state == IDLE;
    out_valid  = state == DONE;
    state_next = (state == IDLE && in_valid) ? CALC :
                 (state == CALC && cnt == '0) ? FIX :
                 (state == FIX) ? DONE :
                 (state == DONE && out_ready) ? IDLE : state;
  end
  // datapath: load operand, iterate one root bit per cycle, then fix up the remainder
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
    end else if (state == IDLE && in_valid) begin
      rad  <= (2*ROOT_W)'(in_data) << FRAC_BITS;
      rem  <= '0;
      root <= '0;
      cnt  <= CW'(ROOT_W - 1);
    end else if (state == CALC) begin
      rad  <= rad << 2;
      rem  <= rem_step;
      root <= {root[ROOT_W-2:0], root_bit};
      cnt  <= cnt - 1'b1;
    end else if (state == FIX) begin
      rem  <= rem_fix;
      root <= root_fin;
    end
endmodule

// File: doc/sqrt_iter.md
# sqrt_iter

Parametrised, multi-cycle integer/fixed-point square-root unit with a valid/ready handshake on both sides. It produces one root bit per clock using a non-restoring algorithm and returns the root and the non-negative remainder. Fractional input bits are supported through a compile-time parameter. It serves as the sequential, throughput-bounded successor to the single-shot ALU sqrt and sits behind the PE ALU op decoder.

## Interface
Parameters:
- DATA_WIDTH, 32, input width; DATA_WIDTH+FRAC_BITS must be even and ≥ 4.
- FRAC_BITS, 0, number of fractional bits in `in_data`. The root carries the same FRAC_BITS.
- ROOT_W (derived, not overridable), (DATA_WIDTH+FRAC_BITS)/2.
- REM_W (derived), ROOT_W+1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operand available.
- in_ready  out  1  unit idle and able to accept.
- in_data  in  DATA_WIDTH  unsigned operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_root  out  ROOT_W  root, unsigned.
- out_rem  out  REM_W  remainder = (in_data<<FRAC_BITS) − root², unsigned.

## Operation
- FSM states are IDLE, CALC, FIX and DONE.
- **IDLE:** in_ready=1. When in_valid&&in_ready, latch the radicand as in_data zero-extended and shifted left by FRAC_BITS, to 2·ROOT_W bits. Clear the root and the partial remainder. Load iteration counter = ROOT_W−1. Go to CALC.
- **CALC:** each cycle consumes the next two radicand bits, MSB first.
  - If the partial remainder ≥ 0: subtract (root<<2|1). Otherwise: add (root<<2|3).
  - Root bit = 1 if the new remainder ≥ 0.
  - The remainder register is REM_W+1 bits, signed.
  - When counter==0, go to FIX; otherwise decrement.
- **FIX:** if the remainder < 0, add (root<<1|1). The result is the final non-negative remainder. Go to DONE.
- **DONE:** out_valid=1 and outputs held stable. When out_ready, go to IDLE.
- in_valid is ignored outside IDLE. in_data is sampled only on the accept edge.
- reset in any state returns to IDLE and discards the operation. No partial result is ever presented.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_root=0, out_rem=0.
- Latency: accept edge at cycle 0, then CALC for cycles 1..ROOT_W, then FIX at ROOT_W+1. out_valid is high from cycle ROOT_W+2.
- Throughput: one operation per ROOT_W+3 cycles minimum. in_ready returns the cycle after the out_valid&&out_ready edge.
- out_valid stays high indefinitely under backpressure, with no change to out_root or out_rem.
- in_ready and out_valid are never high together.

## Configuration
- Macro: SQRT_ITER_ROUND_EN.
- **Defined:** FIX additionally rounds to nearest. If the final remainder > root, out_root = root+1, saturating at 2^ROOT_W−1. out_rem still reports the truncated remainder, so the consumer can reconstruct the truncated root. Latency is unchanged.
- **Undefined:** out_root is floor(sqrt).

## Structure
- Shared package `sqrt_pkg`:
  - state enum (IDLE/CALC/FIX/DONE);
  - width functions root_w(dw,fb) and rem_w(dw,fb);
  - elaboration check on evenness.
- Sub-module `sqrt_step`: combinational single non-restoring iteration.
  - Inputs: remainder, root, two radicand bits.
  - Outputs: next remainder, next root bit.
  - Reused by any future unrolled or multi-bit-per-cycle variant.

## Test plan
1. DATA_WIDTH=32, FRAC_BITS=0, in_data=131072 → out_root=362, out_rem=28. out_valid rises exactly 18 cycles after the accept edge.
2. in_data=0 → root 0, rem 0. in_data=0xFFFFFFFF → root 65535, rem 131070. With SQRT_ITER_ROUND_EN: root stays 65535 (saturation), rem 131070.
3. in_data=15 → root 3, rem 6. With SQRT_ITER_ROUND_EN: root 4, rem 6. in_data=131072 rounded → 362.
4. DATA_WIDTH=16, FRAC_BITS=8, in_data=512 (2.0) → ROOT_W=12, out_root=362 (≈1.414), out_rem=28.
5. Hold out_ready=0 for 20 cycles after out_valid → outputs stable, in_ready=0, new in_valid ignored. Release → in_ready=1 the next cycle.
6. Assert reset in CALC cycle 5 → in_ready=1 and out_valid=0 immediately (asynchronously). The next operand (in_data=144) → root 12, rem 0, with normal latency.
